// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: default sizes and register-index type.
package rv_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned NREG_DEF = 32;
   localparam int unsigned AW_DEF   = $clog2(NREG_DEF);

   typedef logic [AW_DEF-1:0] reg_idx_t;

   // x0 is hardwired to zero
   localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/rv_rf_read_port.sv
// One combinational register-file read port: x0 forcing, optional write
// bypass, otherwise the stored data and busy bit of the addressed entry.
module rv_rf_read_port
   import rv_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEF,
   parameter int unsigned NREG   = NREG_DEF,
   parameter int unsigned AW     = $clog2(NREG),
   parameter int unsigned BYPASS = 1
) (
   input  logic [AW-1:0]             addr,
   input  logic [NREG-1:0][XLEN-1:0] mem,
   input  logic [NREG-1:0]           busy_vec,
   input  logic                      wr_en,
   input  logic [AW-1:0]             wr_addr,
   input  logic [XLEN-1:0]           wr_data,
   output logic [XLEN-1:0]           rd_data,
   output logic                      rd_busy
);

   // Priority: x0, then same-cycle writeback, then stored state.
   always_comb begin
      rd_data = '0;
      rd_busy = 1'b0;
      if (addr == AW'(REG_ZERO)) begin
         rd_data = '0;
         rd_busy = 1'b0;
      end else if ((BYPASS != 0) && wr_en && (wr_addr == addr)) begin
         // A completing writeback resolves the hazard in this cycle.
         rd_data = wr_data;
         rd_busy = 1'b0;
      end else begin
         rd_data = mem[addr];
         rd_busy = busy_vec[addr];
      end
   end

endmodule

// File: rtl/rv_regfile_sb.sv
// RV32I integer register file with NRD read ports, one write port, optional
// write-to-read bypass and a per-register busy scoreboard for RAW detection.
module rv_regfile_sb
   import rv_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEF,
   parameter int unsigned NREG   = NREG_DEF,
   parameter int unsigned AW     = $clog2(NREG),
   parameter int unsigned NRD    = 2,
   parameter int unsigned BYPASS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NRD*AW-1:0]    rd_addr,
   output logic [NRD*XLEN-1:0]  rd_data,
   output logic [NRD-1:0]       rd_busy,
   input  logic                 wr_en,
   input  logic [AW-1:0]        wr_addr,
   input  logic [XLEN-1:0]      wr_data,
   input  logic                 iss_en,
   input  logic [AW-1:0]        iss_addr,
   output logic                 any_busy
);

   logic [NREG-1:0][XLEN-1:0] mem_q;
   logic [NREG-1:0]           busy_q;
   logic [NREG-1:0]           busy_d;
   logic                      wr_ok;
   logic                      iss_ok;
   logic                      byp_en;

   assign wr_ok  = wr_en && (wr_addr != AW'(REG_ZERO));
   assign iss_ok = iss_en && (iss_addr != AW'(REG_ZERO));
   // Keep reads at zero while reset is held, even with a write strobe present.
   assign byp_en = wr_en && !rst;

   // Data storage; every entry is cleared on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '0;
      end else if (wr_ok) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Scoreboard next state: writeback clears, issue sets, issue wins on a tie.
   always_comb begin
      busy_d = busy_q;
      if (wr_ok) begin
         busy_d[wr_addr] = 1'b0;
      end
      if (iss_ok) begin
         busy_d[iss_addr] = 1'b1;
      end
   end

   // Scoreboard register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign any_busy = |busy_q;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      rv_rf_read_port #(
         .XLEN   (XLEN),
         .NREG   (NREG),
         .AW     (AW),
         .BYPASS (BYPASS)
      ) u_port (
         .addr     (rd_addr[i*AW +: AW]),
         .mem      (mem_q),
         .busy_vec (busy_q),
         .wr_en    (byp_en),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .rd_data  (rd_data[i*XLEN +: XLEN]),
         .rd_busy  (rd_busy[i])
      );
   end

endmodule
